// File: rtl/auto_nav_pkg.sv
// Shared encodings and decision helpers for the maze-navigation controller.
package auto_nav_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StMove  = 3'd1,
      StWait  = 3'd2,
      StTurn  = 3'd3,
      StClear = 3'd4
   } nav_state_e;

   typedef enum logic [1:0] {
      DirF      = 2'd0,
      DirL      = 2'd1,
      DirR      = 2'd2,
      DirAround = 2'd3
   } nav_dir_e;

   typedef enum logic [1:0] {
      ClsCorridor = 2'd0,
      ClsBend     = 2'd1,
      ClsDead     = 2'd2,
      ClsFork     = 2'd3
   } nav_cls_e;

   function automatic nav_cls_e classify(input logic f_open, input logic l_open,
                                         input logic r_open);
      logic [1:0] n_open;
      n_open = {1'b0, f_open} + {1'b0, l_open} + {1'b0, r_open};
      if (n_open == 2'd0) return ClsDead;
      if (n_open != 2'd1) return ClsFork;
      return f_open ? ClsCorridor : ClsBend;
   endfunction

   // Wall-follow: prefer the policy side, then straight, then the other side.
   function automatic nav_dir_e policy_choice(input logic right_hand, input logic f_open,
                                              input logic l_open, input logic r_open);
      if (!right_hand) begin
         if (l_open) return DirL;
         if (f_open) return DirF;
         return DirR;
      end
      if (r_open) return DirR;
      if (f_open) return DirF;
      return DirL;
   endfunction

endpackage

// File: rtl/det_debounce.sv
// Tick-based debouncer for one barrier detector; powers up reporting "blocked".
module det_debounce #(
   parameter int unsigned DEB_TICKS = 50
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic db
);

   localparam int unsigned CW = $clog2(DEB_TICKS + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;

   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (raw == db_q) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_q == CW'(DEB_TICKS - 1)) begin
            db_d  = raw;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         db_q  <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         db_q  <= db_d;
      end
   end

   assign db = db_q;

endmodule

// File: rtl/auto_nav_ctrl.sv
// Maze-driving controller: debounced detectors, ms tick prescaler and the
// semi-/full-auto navigation FSM with registered Moore outputs.
module auto_nav_ctrl #(
   parameter int unsigned TICK_DIV    = 100000,
   parameter int unsigned DEB_TICKS   = 50,
   parameter int unsigned TURN_TICKS  = 900,
   parameter int unsigned CLEAR_TICKS = 1500,
   parameter int unsigned WAIT_TICKS  = 0,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             auto_mode,
   input  logic             policy,
   input  logic             front_det,
   input  logic             left_det,
   input  logic             right_det,
   input  logic             back_det,
   input  logic             cmd_forward,
   input  logic             cmd_left,
   input  logic             cmd_right,
   input  logic             cmd_around,
   output logic             move_forward,
   output logic             turn_left,
   output logic             turn_right,
   output logic             waiting,
   output logic [2:0]       state_out,
   output logic [CNT_W-1:0] turn_count
);
   import auto_nav_pkg::*;

   localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned TURN_MAX = 2 * TURN_TICKS;
   localparam int unsigned DUR_MAX  = (TURN_MAX > CLEAR_TICKS) ?
      ((TURN_MAX > WAIT_TICKS) ? TURN_MAX : WAIT_TICKS) :
      ((CLEAR_TICKS > WAIT_TICKS) ? CLEAR_TICKS : WAIT_TICKS);
   localparam int unsigned DW       = $clog2(DUR_MAX + 1);

   logic [TW-1:0] tdiv_q;
   logic          tick;

   assign tick = (tdiv_q == TW'(TICK_DIV - 1));

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst)      tdiv_q <= '0;
      else if (tick) tdiv_q <= '0;
      else           tdiv_q <= tdiv_q + 1'b1;
   end

   logic [3:0] raw_det, db_det;
   logic       back_db_unused;

   assign raw_det        = {back_det, right_det, left_det, front_det};
   assign back_db_unused = db_det[3];

   for (genvar i = 0; i < 4; i++) begin : g_deb
      det_debounce #(
         .DEB_TICKS(DEB_TICKS)
      ) u_deb (
         .sys_clk(sys_clk),
         .rst    (rst),
         .tick   (tick),
         .raw    (raw_det[i]),
         .db     (db_det[i])
      );
   end

   logic     f_open, l_open, r_open;
   nav_cls_e cls;
   nav_dir_e pol_dir;

   assign f_open  = ~db_det[0];
   assign l_open  = ~db_det[1];
   assign r_open  = ~db_det[2];
   assign cls     = classify(f_open, l_open, r_open);
   assign pol_dir = policy_choice(policy, f_open, l_open, r_open);

   // Commands are acted on one cycle after their registered rising edge.
   logic [3:0] cmd_vec, cmd_prev_q, cmd_edge_q;
   assign cmd_vec = {cmd_around, cmd_right, cmd_left, cmd_forward};

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         cmd_prev_q <= '0;
         cmd_edge_q <= '0;
      end else begin
         cmd_prev_q <= cmd_vec;
         cmd_edge_q <= cmd_vec & ~cmd_prev_q;
      end
   end

   nav_state_e       state_q, state_d;
   nav_dir_e         dir_q, dir_d;
   logic [DW-1:0]    dur_q, dur_d, dur_lim;
   logic [CNT_W-1:0] tc_q, tc_d;
   logic             dur_hit;
   logic             mf_q, tl_q, tr_q, wait_q;

   always_comb begin
      case (state_q)
         StTurn:  dur_lim = (dir_q == DirAround) ? DW'(TURN_MAX) : DW'(TURN_TICKS);
         StClear: dur_lim = DW'(CLEAR_TICKS);
         StWait:  dur_lim = DW'(WAIT_TICKS);
         default: dur_lim = '0;
      endcase
   end

   assign dur_hit = tick && (dur_q == dur_lim - 1'b1);

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      dur_d   = tick ? dur_q + 1'b1 : dur_q;
      tc_d    = tc_q;
      case (state_q)
         StIdle: if (enable) state_d = StMove;
         StMove: begin
            case (cls)
               ClsCorridor: state_d = StMove;
               ClsBend: begin
                  state_d = StTurn;
                  dir_d   = l_open ? DirL : DirR;
               end
               ClsDead: begin
                  state_d = StTurn;
                  dir_d   = DirAround;
               end
               default: begin
                  if (auto_mode) begin
                     dir_d   = pol_dir;
                     state_d = (pol_dir == DirF) ? StClear : StTurn;
                  end else begin
                     state_d = StWait;
                  end
               end
            endcase
         end
         StWait: begin
            if (cmd_edge_q[0] && f_open) begin
               state_d = StClear;
               dir_d   = DirF;
            end else if (cmd_edge_q[1] && l_open) begin
               state_d = StTurn;
               dir_d   = DirL;
            end else if (cmd_edge_q[2] && r_open) begin
               state_d = StTurn;
               dir_d   = DirR;
            end else if (cmd_edge_q[3]) begin
               state_d = StTurn;
               dir_d   = DirAround;
            end else if (WAIT_TICKS != 0 && dur_hit) begin
               dir_d   = pol_dir;
               state_d = (pol_dir == DirF) ? StClear : StTurn;
            end
         end
         StTurn:  if (dur_hit) state_d = StClear;
         StClear: if (cls == ClsCorridor || dur_hit) state_d = StMove;
         default: state_d = StIdle;
      endcase
      if (!enable) state_d = StIdle;
      if (state_d != state_q) dur_d = '0;
      if (state_d == StTurn && state_q != StTurn && tc_q != '1) tc_d = tc_q + 1'b1;
   end

   // Outputs are registered from the next state so they always match state_q/dir_q.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         dir_q   <= DirF;
         dur_q   <= '0;
         tc_q    <= '0;
         mf_q    <= 1'b0;
         tl_q    <= 1'b0;
         tr_q    <= 1'b0;
         wait_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         dur_q   <= dur_d;
         tc_q    <= tc_d;
         mf_q    <= (state_d == StMove) || (state_d == StClear);
         tl_q    <= (state_d == StTurn) && ((dir_d == DirL) || (dir_d == DirAround));
         tr_q    <= (state_d == StTurn) && (dir_d == DirR);
         wait_q  <= (state_d == StWait);
      end
   end

   assign move_forward = mf_q;
   assign turn_left    = tl_q;
   assign turn_right   = tr_q;
   assign waiting      = wait_q;
   assign state_out    = state_q;
   assign turn_count   = tc_q;

endmodule
